// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel among NUM_REQ requesters, with message locking.
// Optional per-requester byte counters are built when UART_ARB_STATS_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         uart_data_in,
    output logic                          uart_data_in_valid,
    input  logic                          uart_data_in_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [NUM_REQ*16-1:0]         stat_count
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, OWN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [7:0]       burst_q, burst_d;

    logic             any_valid;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             xfer;
    logic             release_now;
    logic [7:0]       burst_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= IDX_W'(NUM_REQ - 1);
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            burst_q    <= burst_d;
        end
    end

    // First valid requester scanning upward from last_ptr+1, wrapping.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_ptr_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    always_comb begin
        xfer        = (state_q == OWN) && req_valid[owner_q] && uart_data_in_ready;
        burst_inc   = burst_q + 8'd1;
        release_now = xfer && (req_last[owner_q] || (burst_inc == 8'(MAX_BURST)));
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        burst_d    = burst_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = OWN;
                    owner_d = pick;
                    burst_d = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    burst_d = burst_inc;
                    if (release_now) begin
                        state_d    = IDLE;
                        last_ptr_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant              = '0;
        req_ready          = '0;
        uart_data_in       = '0;
        uart_data_in_valid = 1'b0;
        busy               = 1'b0;
        if (state_q == OWN) begin
            grant[owner_q]     = 1'b1;
            busy               = 1'b1;
            req_ready[owner_q] = uart_data_in_ready;
            uart_data_in       = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            uart_data_in_valid = req_valid[owner_q];
        end
    end

`ifdef UART_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];
    logic [15:0] stat_d [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (xfer && (owner_q == IDX_W'(i)) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_count[i*16 +: 16] = stat_q[i];
        end
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (NUM_REQ=2, DATA_WIDTH=8, MAX_BURST=16).
module tb_uart_tx_arbiter;
    localparam int unsigned N  = 2;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   uart_data_in;
    logic           uart_data_in_valid;
    logic           uart_data_in_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N*16-1:0] stat_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(W),
        .MAX_BURST (MB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_data          (req_data),
        .req_valid         (req_valid),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .uart_data_in      (uart_data_in),
        .uart_data_in_valid(uart_data_in_valid),
        .uart_data_in_ready(uart_data_in_ready),
        .grant             (grant),
        .busy              (busy),
        .stat_count        (stat_count)
    );

    // Source queues hold {last, data}; scoreboard holds {expected grant, data}.
    logic [8:0]  src0 [$];
    logic [8:0]  src1 [$];
    logic [9:0]  exp_q [$];
    logic [1:0]  gnt_log [$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned nxfer    = 0;
    int unsigned nrel     = 0;
    int unsigned viol     = 0;
    logic [1:0]  prev_g   = '0;
    bit          toggle_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        if (src0.size() != 0) begin
            req_valid[0]   = 1'b1;
            req_last[0]    = src0[0][8];
            req_data[7:0]  = src0[0][7:0];
        end
        if (src1.size() != 0) begin
            req_valid[1]   = 1'b1;
            req_last[1]    = src1[0][8];
            req_data[15:8] = src1[0][7:0];
        end
    endtask

    task automatic send(input int r, input int n, input logic [7:0] base, input bit last);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            e[8]   = last && (i == n - 1);
            e[7:0] = base + 8'(i);
            if (r == 0) src0.push_back(e);
            else        src1.push_back(e);
            exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, e[7:0]});
        end
    endtask

    task automatic tick();
        logic [1:0] fired;
        logic [9:0] e;
        @(negedge clk);
        gnt_log.push_back(grant);
        fired = req_valid & req_ready;
        if (uart_data_in_valid && uart_data_in_ready) begin
            nxfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {grant, uart_data_in}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("xfer", {grant, uart_data_in}, e);
            end
        end
        if (uart_data_in_valid && (grant == '0)) viol++;
        if ((grant & (grant - 2'd1)) != '0) viol++;
        if (req_ready !== (grant & {N{uart_data_in_ready}})) viol++;
        if ((prev_g != '0) && (grant != '0) && (grant != prev_g)) viol++;
        if ((prev_g != '0) && (grant == '0)) nrel++;
        prev_g = grant;
        @(posedge clk);
        #1;
        if (fired[0] && src0.size() != 0) void'(src0.pop_front());
        if (fired[1] && src1.size() != 0) void'(src1.pop_front());
        if (toggle_rdy) uart_data_in_ready = ~uart_data_in_ready;
        drive();
    endtask

    task automatic run(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        chk("drain_budget", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src0.delete();
        src1.delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_g = '0;
        nrel   = 0;
        nxfer  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        uart_data_in_ready = 1'b1;
        drive();
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_valid", uart_data_in_valid, 0);
        chk("rst_data", uart_data_in, 0);
        chk("rst_stat", stat_count, 0);
        do_reset();

        // Single 3-byte message: one-cycle grant latency, consecutive transfers, then release.
        gnt_log.delete();
        send(0, 3, 8'h41, 1'b1);
        drive();
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t1_grant_seq", gnt_log[i], (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
        end
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_busy_after", busy, 0);

        // Two simultaneous requesters, two rounds of rotation.
        do_reset();
        send(0, 2, 8'hA0, 1'b1);
        send(1, 2, 8'hB0, 1'b1);
        drive();
        run(30);
        send(0, 2, 8'hA2, 1'b1);
        send(1, 2, 8'hB2, 1'b1);
        drive();
        run(30);
        repeat (2) tick();
        chk("t2_releases", nrel, 4);

        // Burst cap: 20 bytes without last from req1.
        do_reset();
        send(1, 20, 8'h10, 1'b0);
        drive();
        run(60);
        repeat (2) tick();
        chk("t3_releases", nrel, 1);
        chk("t3_grant_held", grant, 2'b10);
        chk("t3_busy_held", busy, 1);
        chk("t3_valid_low", uart_data_in_valid, 0);

        // UART ready toggling every cycle during a 4-byte message.
        do_reset();
        uart_data_in_ready = 1'b0;
        toggle_rdy = 1'b1;
        send(0, 4, 8'h60, 1'b1);
        drive();
        run(40);
        repeat (2) tick();
        chk("t4_xfer_count", nxfer, 4);
        chk("t4_grant_idle", grant, 0);
        toggle_rdy = 1'b0;
        uart_data_in_ready = 1'b1;

        // Reset in the middle of a 5-byte message after two bytes.
        do_reset();
        send(1, 5, 8'h70, 1'b1);
        drive();
        for (int i = 0; i < 20 && nxfer < 2; i++) tick();
        chk("t5_two_sent", nxfer, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", grant, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_valid", uart_data_in_valid, 0);
        do_reset();
        send(0, 1, 8'h50, 1'b1);
        send(1, 5, 8'h70, 1'b1);
        drive();
        run(40);

        // Per-requester byte counters.
        do_reset();
        send(0, 5, 8'h80, 1'b1);
        send(1, 3, 8'h90, 1'b1);
        drive();
        run(40);
        repeat (2) tick();
`ifdef UART_ARB_STATS_EN
        chk("t6_stats", stat_count, {16'd3, 16'd5});
`else
        chk("t6_stats", stat_count, 0);
`endif

        chk("protocol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte channel (DataIn/DataInValid/DataInReady) among NUM_REQ requesters, e.g. CPU MMIO TX and a debug/echo source.
- Round-robin arbitration with message locking: a granted requester keeps the channel until its last byte, or until MAX_BURST bytes, then the grant rotates.
- Sits between the requesters and the UART DataIn side inside the Riscv151 top level.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- DATA_WIDTH, 8, byte width of each requester and of the UART.
- MAX_BURST, 16, maximum bytes per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_data  input  NUM_REQ*DATA_WIDTH  requester bytes; requester i occupies bits [i*8 +: 8].
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_last  input  NUM_REQ  marks the final byte of a message; sampled with req_valid.
- req_ready  output  NUM_REQ  per-requester byte accepted.
- uart_data_in  output  DATA_WIDTH  to UART DataIn.
- uart_data_in_valid  output  1  to UART DataInValid.
- uart_data_in_ready  input  1  from UART DataInReady.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while any grant is held.
- stat_count  output  NUM_REQ*16  per-requester byte counters; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, busy=0, req_ready=0, uart_data_in_valid=0, uart_data_in=0.
  - FSM enters IDLE; burst counter=0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - req_ready=0 and uart_data_in_valid=0.
  - If any req_valid is high, the next clock edge registers a grant for the first valid requester searching upward (with wrap) from last_ptr+1. FSM moves to OWN, burst counter clears, busy=1.
- OWN, owner g:
  - Combinational pass-through: uart_data_in=req_data[g], uart_data_in_valid=req_valid[g], req_ready[g]=uart_data_in_ready. All other req_ready=0.
  - A transfer occurs when req_valid[g] & uart_data_in_ready are both high on a clock edge. Each transfer increments the 8-bit burst counter.
  - Release on a transfer with req_last[g]=1, or on the transfer that brings the burst counter to MAX_BURST.
  - On release: the next edge gives grant=0, busy=0, last_ptr=g, FSM to IDLE.
- Arbitration latency:
  - 1 cycle from req_valid to grant when IDLE.
  - 1 idle bubble cycle between grants; this is mandatory, and no back-to-back grant change is allowed.
- If the owner drops req_valid mid-message, the grant is held indefinitely; there is no timeout. uart_data_in_valid follows req_valid[g].
- Non-owner valids are ignored while OWN. They must hold their data stable until granted and accepted.
- Simultaneous requests resolve purely by rotating priority. A single active requester is re-granted after each release, following the bubble.
- Reset mid-message: the grant is dropped immediately. A byte the UART already accepted is not recalled. The requester restarts its message after reset.
- uart_data_in_valid never asserts without a grant, and grant is always one-hot or zero.

Optional Feature:
- Macro UART_ARB_STATS_EN.
- Defined: stat_count[i*16 +: 16] increments on each transfer from requester i and saturates at 16'hFFFF. Cleared by reset only.
- Undefined: stat_count is tied to 0, no counter flops are synthesized, and all other behaviour is identical.

Test Plan:
- Req0 sends 3 bytes 8'h41,8'h42,8'h43 (last on 8'h43), UART always ready -> grant=2'b01 one cycle after valid; three transfers on consecutive cycles; grant=0 on the following cycle.
- Req0 and Req1 both valid from reset, each sending a 2-byte message -> req0 served first, 1-cycle bubble, then req1; on the next round req1 has lost priority, so req0 is served first again only if last_ptr=1.
- Req1 streams 20 bytes with no last, MAX_BURST=16 -> release after byte 16, bubble, regrant to req1 (sole requester), remaining 4 bytes follow; 20 bytes total in order.
- uart_data_in_ready toggles 0/1 every cycle during a 4-byte message -> exactly 4 transfers; data is never duplicated or skipped; req_ready mirrors uart_data_in_ready only for the owner.
- rst_n asserted low mid-message after 2 of 5 bytes -> grant, busy and uart_data_in_valid drop to 0 asynchronously; after release, the first grant goes to req0.
- With UART_ARB_STATS_EN: req0 sends 5 bytes and req1 sends 3 -> stat_count = {16'd3,16'd5}. Without the macro -> stat_count=0.
